// File: rtl/rr_channel_mux_pkg.sv
// Shared constants and helpers for the round-robin channel mux.
package rr_channel_mux_pkg;

   localparam int MODE_RR    = 0;
   localparam int MODE_FIXED = 1;

   // Smallest r with 2**r >= v, never below 1 so single-bit selects stay legal.
   function automatic int clog2(input int v);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << r) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Purpose: pick the first set request starting at ptr (rr) or at index 0 (fixed).
// Latency: purely combinational.
// Backpressure: none; caller gates the result with its own load condition.
module rr_priority_pick #(
   parameter int N  = 4,
   parameter int SW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [SW-1:0] ptr,
   input  logic          mode,
   output logic          gnt_valid,
   output logic [SW-1:0] gnt_idx
);

   logic [SW-1:0]  base;
   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;
   logic [SW:0]    sum;

   assign base = mode ? '0 : ptr;
   assign dbl  = {req, req};
   assign rot  = dbl[base +: N];

   // Descending scan so the lowest rotated offset is the last (winning) write.
   always_comb begin
      gnt_valid = 1'b0;
      sum       = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (rot[k]) begin
            gnt_valid = 1'b1;
            sum       = {1'b0, base} + (SW+1)'(k);
         end
      end
   end

   assign gnt_idx = (sum >= (SW+1)'(N)) ? SW'(sum - (SW+1)'(N)) : SW'(sum);

endmodule

// File: rtl/rr_channel_mux.sv
// Purpose: arbitrate N valid/ready channels onto one registered output (rr or fixed priority).
// Latency: 1 clk from accepted input beat to out_valid.
// Backpressure: in_ready is zero while a held beat stalls; no bubble when out_ready=1.
module rr_channel_mux
   import rr_channel_mux_pkg::*;
#(
   parameter  int N    = 4,
   parameter  int W    = 16,
   parameter  int MODE = MODE_RR,
   localparam int SW   = clog2(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   in_valid,
   input  logic [N*W-1:0] in_data,
   input  logic [N-1:0]   chan_en,
   output logic [N-1:0]   in_ready,
   output logic           out_valid,
   output logic [W-1:0]   out_data,
   output logic [SW-1:0]  out_sel,
   input  logic           out_ready
);

   logic [N-1:0]  req;
   logic          load;
   logic          xfer;
   logic          gnt_valid;
   logic [SW-1:0] gnt_idx;
   logic [SW-1:0] ptr;
   logic [W-1:0]  gnt_dat;

   assign load = ~out_valid | out_ready;
   assign req  = in_valid & chan_en;

   rr_priority_pick #(
      .N  (N),
      .SW (SW)
   ) u_pick (
      .req       (req),
      .ptr       (ptr),
      .mode      (MODE == MODE_FIXED),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

   always_comb begin
      gnt_dat  = '0;
      in_ready = '0;
      for (int i = 0; i < N; i++) begin
         if (gnt_idx == SW'(i)) begin
            gnt_dat     = in_data[i*W +: W];
            in_ready[i] = ~rst & load & gnt_valid;
         end
      end
   end

   assign xfer = |(in_valid & in_ready);

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         ptr       <= '0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= gnt_dat;
         out_sel   <= gnt_idx;
         // Fixed mode leaves ptr at zero; the picker ignores it there.
         if (MODE == MODE_RR) begin
            ptr <= (gnt_idx == SW'(N - 1)) ? '0 : gnt_idx + 1'b1;
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rr_channel_mux.sv
// Bench: round-robin and fixed-priority instances driven in lockstep, checked against a queue-free behavioural model.
module tb_rr_channel_mux;

   localparam int N  = 4;
   localparam int W  = 16;
   localparam int SW = 2;

   logic           clk;
   logic           rst;
   logic [N-1:0]   in_valid;
   logic [N*W-1:0] in_data;
   logic [N-1:0]   chan_en;
   logic           out_ready;

   logic [N-1:0]   rdy0, rdy1;
   logic           ov0, ov1;
   logic [W-1:0]   od0, od1;
   logic [SW-1:0]  os0, os1;

   int checks   = 0;
   int failures = 0;

   rr_channel_mux #(.N(N), .W(W), .MODE(0)) dut_rr (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .chan_en(chan_en),
      .in_ready(rdy0), .out_valid(ov0), .out_data(od0), .out_sel(os0), .out_ready(out_ready)
   );

   rr_channel_mux #(.N(N), .W(W), .MODE(1)) dut_fx (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .chan_en(chan_en),
      .in_ready(rdy1), .out_valid(ov1), .out_data(od1), .out_sel(os1), .out_ready(out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model state per instance: index 0 = round-robin, 1 = fixed priority.
   logic         m_ov  [2];
   logic [W-1:0] m_od  [2];
   int           m_os  [2];
   int           m_ptr [2];

   initial begin
      for (int m = 0; m < 2; m++) begin
         m_ov[m] = 1'b0; m_od[m] = '0; m_os[m] = 0; m_ptr[m] = 0;
      end
   end

   // Which channel the rules say is granted this cycle, or -1.
   function automatic int model_grant(input int m);
      logic [N-1:0] req;
      int c;
      if (rst) return -1;
      if (m_ov[m] && !out_ready) return -1;
      req = in_valid & chan_en;
      for (int k = 0; k < N; k++) begin
         c = (m == 0) ? (m_ptr[m] + k) % N : k;
         if (req[c]) return c;
      end
      return -1;
   endfunction

   always @(negedge clk) begin
      int g;
      logic [N-1:0] er;
      for (int m = 0; m < 2; m++) begin
         g  = model_grant(m);
         er = (g < 0) ? '0 : N'(1) << g;
         chk(m == 0 ? "rr in_ready"  : "fx in_ready",  m == 0 ? 32'(rdy0) : 32'(rdy1), 32'(er));
         chk(m == 0 ? "rr out_valid" : "fx out_valid", m == 0 ? 32'(ov0)  : 32'(ov1),  32'(m_ov[m]));
         chk(m == 0 ? "rr out_data"  : "fx out_data",  m == 0 ? 32'(od0)  : 32'(od1),  32'(m_od[m]));
         chk(m == 0 ? "rr out_sel"   : "fx out_sel",   m == 0 ? 32'(os0)  : 32'(os1),  32'(m_os[m]));
         if (rst) begin
            m_ov[m] = 1'b0; m_od[m] = '0; m_os[m] = 0; m_ptr[m] = 0;
         end else if (g >= 0) begin
            m_ov[m] = 1'b1;
            m_od[m] = in_data[g*W +: W];
            m_os[m] = g;
            if (m == 0) m_ptr[m] = (g + 1) % N;
         end else if (out_ready) begin
            m_ov[m] = 1'b0;
         end
      end
   end

   task automatic drive_edge();
      @(posedge clk);
      #1;
   endtask

   localparam logic [N*W-1:0] IDX_DATA = {16'd3, 16'd2, 16'd1, 16'd0};

   initial begin
      rst       = 1'b1;
      in_valid  = 4'hF;
      chan_en   = 4'hF;
      out_ready = 1'b1;
      in_data   = IDX_DATA;

      // Reset held with every channel valid.
      repeat (3) @(negedge clk);
      chk("reset out_valid", 32'(ov0), 32'd0);
      chk("reset out_sel",   32'(os0), 32'd0);
      chk("reset in_ready",  32'(rdy0), 32'd0);
      drive_edge();
      rst = 1'b0;
      @(negedge clk);
      chk("first grant rr", 32'(rdy0), 32'b0001);
      chk("first grant fx", 32'(rdy1), 32'b0001);

      // Round-robin fairness vs fixed priority.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("rr seq sel",   32'(os0), 32'(i % 4));
         chk("rr seq valid", 32'(ov0), 32'd1);
         chk("fx seq sel",   32'(os1), 32'd0);
      end
      drive_edge();
      in_valid = 4'b1110;
      @(negedge clk);
      @(negedge clk);
      chk("fx drop ch0 sel", 32'(os1), 32'd1);

      // Backpressure on a beat from ch2.
      drive_edge();
      rst = 1'b1;
      drive_edge();
      rst       = 1'b0;
      in_valid  = 4'b0100;
      in_data   = {16'd3, 16'hA5A5, 16'd1, 16'd0};
      out_ready = 1'b0;
      drive_edge();
      in_valid = 4'hF;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall data",  32'(od0), 32'hA5A5);
         chk("stall sel",   32'(os0), 32'd2);
         chk("stall ready", 32'(rdy0), 32'd0);
      end
      drive_edge();
      out_ready = 1'b1;
      @(negedge clk);
      chk("release grant rr", 32'(rdy0), 32'b1000);
      chk("release grant fx", 32'(rdy1), 32'b0001);

      // Mask and pointer wrap.
      drive_edge();
      rst = 1'b1;
      drive_edge();
      rst     = 1'b0;
      chan_en = 4'b1001;
      in_data = IDX_DATA;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("mask rr sel", 32'(os0), (i % 2) ? 32'd3 : 32'd0);
         chk("mask fx sel", 32'(os1), 32'd0);
      end
      drive_edge();
      in_valid = 4'b1000;
      @(negedge clk);
      chk("mask rr sel last", 32'(os0), 32'd3);
      chk("only ch3 rr",      32'(rdy0), 32'b1000);
      chk("only ch3 fx",      32'(rdy1), 32'b1000);
      drive_edge();
      in_valid = 4'hF;
      @(negedge clk);
      chk("wrap sel",   32'(os0), 32'd3);
      chk("wrap grant", 32'(rdy0), 32'b0001);

      // Reset while a beat is stalled.
      drive_edge();
      out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("held before rst", 32'(ov0), 32'd1);
      drive_edge();
      rst = 1'b1;
      @(negedge clk);
      chk("ready in rst", 32'(rdy0), 32'd0);
      drive_edge();
      rst = 1'b0;
      @(negedge clk);
      chk("held beat dropped", 32'(ov0), 32'd0);
      chk("ptr after rst",     32'(rdy0), 32'b0001);

      // Random traffic; the negedge process checks every cycle.
      repeat (4000) begin
         drive_edge();
         rst       = ($urandom_range(0, 99) == 0);
         in_valid  = N'($urandom);
         chan_en   = ($urandom_range(0, 3) == 0) ? N'($urandom) : 4'hF;
         out_ready = ($urandom_range(0, 3) != 0);
         in_data   = {$urandom, $urandom};
      end
      @(negedge clk);
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
